eth_tx_sched_mux: RTL and testbench

ETH_TX_SCHED_MUX -- requirements
Module: eth_tx_sched_mux

---
 rtl/eth_pkg.sv | 20 ++
 rtl/eth_rr_arbiter.sv | 39 +++
 rtl/eth_tx_sched_mux.sv | 186 ++++++++++++++++++
 tb/tb_eth_tx_sched_mux.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// ----------------------------------------------------------------------------
// eth_pkg
// Shared definitions for the Ethernet TX scheduling path:
//   - tx_state_e            : scheduler FSM state encoding
//   - QUANTA_CYCLES_DEFAULT : tx_clk cycles per pause quantum (512 bit times
//                             at 1G with an 8-bit datapath)
//   - PAUSE_QUANTA_W        : width of the pause_quanta field from the MAC
// ----------------------------------------------------------------------------
package eth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_PAUSE = 2'd2
    } tx_state_e;

    localparam int QUANTA_CYCLES_DEFAULT = 64;
    localparam int PAUSE_QUANTA_W        = 16;

endpackage

// File: rtl/eth_rr_arbiter.sv
// ----------------------------------------------------------------------------
// eth_rr_arbiter
// Combinational round-robin grant selection. The search starts at the channel
// after the last grant and wraps; the first requester found wins.
//
// Ports:
//   req_i        [CHANNELS]        request vector (one bit per channel)
//   last_grant_i [clog2(CHANNELS)] index of the previously granted channel
//   grant_o      [clog2(CHANNELS)] winning channel index (0 when none)
//   valid_o                        at least one request present
// ----------------------------------------------------------------------------
module eth_rr_arbiter #(
    parameter int CHANNELS = 4
) (
    input  logic [CHANNELS-1:0]         req_i,
    input  logic [$clog2(CHANNELS)-1:0] last_grant_i,
    output logic [$clog2(CHANNELS)-1:0] grant_o,
    output logic                        valid_o
);

    localparam int IW = $clog2(CHANNELS);

    // Walk offsets from farthest to nearest so the nearest requester after
    // last_grant_i is the final (winning) assignment.
    always_comb begin
        int idx;
        idx     = 0;
        grant_o = '0;
        valid_o = 1'b0;
        for (int off = CHANNELS; off >= 1; off--) begin
            idx = (int'(last_grant_i) + off) % CHANNELS;
            if (req_i[idx]) begin
                grant_o = IW'(idx);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_tx_sched_mux.sv
// ----------------------------------------------------------------------------
// eth_tx_sched_mux
// Multiplexes CHANNELS 8-bit AXI-Stream TX sources onto one MAC TX stream.
// Whole frames are granted round-robin; a MAC PAUSE request holds off new
// grants (never truncating a frame in flight) for pause_quanta quanta.
// Per-channel good/bad frame counters are bumped on each tlast handshake.
//
// Ports:
//   tx_clk, tx_rst                 clock, asynchronous active-high reset
//   s_axis_t{data,valid,last,user} per-channel inputs (channel n on slice n)
//   s_axis_tready                  per-channel ready (only granted channel)
//   m_axis_t{data,valid,last,user} muxed stream to MAC TX
//   m_axis_tready                  MAC ready
//   pause_req, pause_quanta        one-cycle load of the pause timer
//   pause_active                   pause timer nonzero
//   active_ch, busy                current grant, frame in progress
//   good_frame_cnt, bad_frame_cnt  packed per-channel frame counters
// ----------------------------------------------------------------------------
module eth_tx_sched_mux
    import eth_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int CNT_WIDTH     = 16,
    parameter int QUANTA_CYCLES = QUANTA_CYCLES_DEFAULT,
    parameter bit PAUSE_ENABLE  = 1'b1
) (
    input  logic                          tx_clk,
    input  logic                          tx_rst,

    input  logic [CHANNELS*8-1:0]         s_axis_tdata,
    input  logic [CHANNELS-1:0]           s_axis_tvalid,
    input  logic [CHANNELS-1:0]           s_axis_tlast,
    input  logic [CHANNELS-1:0]           s_axis_tuser,
    output logic [CHANNELS-1:0]           s_axis_tready,

    output logic [7:0]                    m_axis_tdata,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tuser,
    input  logic                          m_axis_tready,

    input  logic                          pause_req,
    input  logic [PAUSE_QUANTA_W-1:0]     pause_quanta,
    output logic                          pause_active,

    output logic [$clog2(CHANNELS)-1:0]   active_ch,
    output logic                          busy,

    output logic [CHANNELS*CNT_WIDTH-1:0] good_frame_cnt,
    output logic [CHANNELS*CNT_WIDTH-1:0] bad_frame_cnt
);

    localparam int IW  = $clog2(CHANNELS);
    // Wide enough for 0xFFFF * QUANTA_CYCLES.
    localparam int PCW = PAUSE_QUANTA_W + $clog2(QUANTA_CYCLES) + 1;

    tx_state_e          state_q;
    logic [IW-1:0]      grant_q;
    logic [IW-1:0]      last_grant_q;
    logic [CNT_WIDTH-1:0] good_cnt_q [CHANNELS];
    logic [CNT_WIDTH-1:0] bad_cnt_q  [CHANNELS];

    logic [7:0]         ch_data [CHANNELS];
    logic [IW-1:0]      arb_grant;
    logic               arb_valid;
    logic               in_xfer;
    logic               eof_hs;
    logic               pause_hold;

    // ------------------------------------------------------------------
    // Per-channel unpacking and output packing
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        assign ch_data[gi]       = s_axis_tdata[gi*8 +: 8];
        assign s_axis_tready[gi] = in_xfer && (grant_q == IW'(gi)) && m_axis_tready;
        assign good_frame_cnt[gi*CNT_WIDTH +: CNT_WIDTH] = good_cnt_q[gi];
        assign bad_frame_cnt[gi*CNT_WIDTH +: CNT_WIDTH]  = bad_cnt_q[gi];
    end

    // ------------------------------------------------------------------
    // Pause timer
    // ------------------------------------------------------------------
    if (PAUSE_ENABLE) begin : g_pause
        logic [PCW-1:0] pause_cnt_q;
        logic [PCW-1:0] pause_cnt_d;

        // A new request always overwrites the running count; quanta 0
        // therefore cancels any pause in progress.
        always_comb begin
            pause_cnt_d = pause_cnt_q;
            if (pause_req) begin
                pause_cnt_d = PCW'(pause_quanta) * PCW'(QUANTA_CYCLES);
            end else if (pause_cnt_q != '0) begin
                pause_cnt_d = pause_cnt_q - PCW'(1);
            end
        end

        always_ff @(posedge tx_clk or posedge tx_rst) begin
            if (tx_rst) begin
                pause_cnt_q <= '0;
            end else begin
                pause_cnt_q <= pause_cnt_d;
            end
        end

        // Looking at the next count lets a request arriving in the same
        // cycle as an IDLE grant decision win over the grant.
        assign pause_hold   = (pause_cnt_d != '0);
        assign pause_active = (pause_cnt_q != '0);
    end else begin : g_no_pause
        logic unused_pause;
        assign unused_pause = ^{pause_req, pause_quanta};
        assign pause_hold   = 1'b0;
        assign pause_active = 1'b0;
    end

    // ------------------------------------------------------------------
    // Arbiter
    // ------------------------------------------------------------------
    eth_rr_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_arb (
        .req_i        (s_axis_tvalid),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant),
        .valid_o      (arb_valid)
    );

    // ------------------------------------------------------------------
    // Datapath mux (combinational from the registered grant)
    // ------------------------------------------------------------------
    assign in_xfer       = (state_q == ST_XFER);
    assign m_axis_tdata  = in_xfer ? ch_data[grant_q] : 8'h00;
    assign m_axis_tvalid = in_xfer && s_axis_tvalid[grant_q];
    assign m_axis_tlast  = in_xfer && s_axis_tlast[grant_q];
    assign m_axis_tuser  = in_xfer && s_axis_tuser[grant_q];
    assign eof_hs        = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    assign active_ch = grant_q;
    assign busy      = in_xfer;

    // ------------------------------------------------------------------
    // Scheduler FSM and frame counters
    // ------------------------------------------------------------------
    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= IW'(CHANNELS - 1);
            for (int i = 0; i < CHANNELS; i++) begin
                good_cnt_q[i] <= '0;
                bad_cnt_q[i]  <= '0;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pause_hold) begin
                        state_q <= ST_PAUSE;
                    end else if (arb_valid) begin
                        grant_q      <= arb_grant;
                        last_grant_q <= arb_grant;
                        state_q      <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    // Frames are atomic: only the tlast handshake leaves XFER.
                    if (eof_hs) begin
                        state_q <= ST_IDLE;
                        if (m_axis_tuser) begin
                            bad_cnt_q[grant_q] <= bad_cnt_q[grant_q] + CNT_WIDTH'(1);
                        end else begin
                            good_cnt_q[grant_q] <= good_cnt_q[grant_q] + CNT_WIDTH'(1);
                        end
                    end
                end
                ST_PAUSE: begin
                    if (!pause_hold) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_sched_mux.sv
// ----------------------------------------------------------------------------
// tb_eth_tx_sched_mux
// Directed bench: a table of arbitration scenarios plus hand-written
// sequences for counter wrap, pause, pause cancel and reset mid-frame.
// Sources emit bytes {ch[1:0], frame_no[1:0], idx[3:0]} so the output
// stream can be checked for order, drops and duplicates.
// ----------------------------------------------------------------------------
module tb_eth_tx_sched_mux;

    localparam int CH = 4;
    localparam int CW = 4;
    localparam int QC = 64;

    logic              tx_clk = 1'b0;
    logic              tx_rst = 1'b1;
    logic [CH*8-1:0]   s_axis_tdata  = '0;
    logic [CH-1:0]     s_axis_tvalid = '0;
    logic [CH-1:0]     s_axis_tlast  = '0;
    logic [CH-1:0]     s_axis_tuser  = '0;
    logic [CH-1:0]     s_axis_tready;
    logic [7:0]        m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tuser;
    logic              m_axis_tready = 1'b1;
    logic              pause_req     = 1'b0;
    logic [15:0]       pause_quanta  = '0;
    logic              pause_active;
    logic [1:0]        active_ch;
    logic              busy;
    logic [CH*CW-1:0]  good_frame_cnt;
    logic [CH*CW-1:0]  bad_frame_cnt;

    eth_tx_sched_mux #(
        .CHANNELS      (CH),
        .CNT_WIDTH     (CW),
        .QUANTA_CYCLES (QC),
        .PAUSE_ENABLE  (1'b1)
    ) dut (
        .tx_clk         (tx_clk),
        .tx_rst         (tx_rst),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tuser   (s_axis_tuser),
        .s_axis_tready  (s_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tuser   (m_axis_tuser),
        .m_axis_tready  (m_axis_tready),
        .pause_req      (pause_req),
        .pause_quanta   (pause_quanta),
        .pause_active   (pause_active),
        .active_ch      (active_ch),
        .busy           (busy),
        .good_frame_cnt (good_frame_cnt),
        .bad_frame_cnt  (bad_frame_cnt)
    );

    always #5 tx_clk = ~tx_clk;

    typedef struct {
        logic [3:0]  mask;      // channels with frames queued
        int          nframes;   // frames per active channel
        int          len;       // bytes per frame
        logic [3:0]  bad_mask;  // channels whose frames end with tuser=1
        bit          toggle;    // toggle m_axis_tready every cycle
        int          norder;    // number of frames expected on output
        logic [47:0] order;     // expected grant order, nibble k = frame k
        logic [15:0] exp_good;  // nibble n = good count of channel n
        logic [15:0] exp_bad;
    } vec_t;

    vec_t vecs [5];

    int         total = 0;
    int         bad   = 0;
    int         cyc;
    int         len_g;
    logic [3:0] bad_mask_g;
    bit         toggle_g;
    int         frames_left  [CH];
    int         byte_idx     [CH];
    int         frame_no     [CH];
    int         out_frame_no [CH];
    int         exp_order [$];
    int         ord_ptr;
    int         exp_idx;
    bit         prev_eof;
    int         pulse_at;
    int         pause_hi_cnt;
    bit         pause_chk;

    function automatic logic [7:0] mk_byte(input int ch, input int fno, input int idx);
        return 8'((ch % 4) * 64 + (fno % 4) * 16 + (idx % 16));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_inputs();
        for (int n = 0; n < CH; n++) begin
            s_axis_tvalid[n]       = (frames_left[n] != 0);
            s_axis_tdata[n*8 +: 8] = mk_byte(n, frame_no[n], byte_idx[n]);
            s_axis_tlast[n]        = (byte_idx[n] == len_g - 1);
            s_axis_tuser[n]        = (byte_idx[n] == len_g - 1) && bad_mask_g[n];
        end
    endtask

    task automatic do_reset();
        tx_rst        = 1'b1;
        pause_req     = 1'b0;
        pause_quanta  = '0;
        m_axis_tready = 1'b1;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tlast  = '0;
        s_axis_tuser  = '0;
        repeat (2) @(negedge tx_clk);
        check("rst_m_tvalid", m_axis_tvalid, 0);
        check("rst_s_tready", s_axis_tready, 0);
        check("rst_busy", busy, 0);
        check("rst_pause_active", pause_active, 0);
        check("rst_active_ch", active_ch, 0);
        check("rst_good_cnt", good_frame_cnt, 0);
        check("rst_bad_cnt", bad_frame_cnt, 0);
    endtask

    // Called at a negedge while reset is held; releases reset.
    task automatic setup(input logic [3:0] mask, input int nframes, input int len,
                         input logic [3:0] bm, input bit tog);
        len_g      = len;
        bad_mask_g = bm;
        toggle_g   = tog;
        for (int n = 0; n < CH; n++) begin
            frames_left[n]  = mask[n] ? nframes : 0;
            byte_idx[n]     = 0;
            frame_no[n]     = 0;
            out_frame_no[n] = 0;
        end
        ord_ptr      = 0;
        exp_idx      = 0;
        prev_eof     = 1'b0;
        cyc          = 0;
        pulse_at     = -1;
        pause_hi_cnt = 0;
        pause_chk    = 1'b0;
        drive_inputs();
        tx_rst = 1'b0;
    endtask

    task automatic cycle();
        logic [CH-1:0] hs;
        int            ech;
        bit            exp_last;
        @(negedge tx_clk);
        hs = s_axis_tvalid & s_axis_tready;
        if (cyc == 0 && exp_order.size() > 0) begin
            check("first_grant_busy", busy, 1);
            check("first_grant_ch", active_ch, exp_order[0]);
        end
        if (prev_eof) begin
            check("idle_gap_busy", busy, 0);
            check("idle_gap_tvalid", m_axis_tvalid, 0);
        end
        if (!busy) check("idle_tready", s_axis_tready, 0);
        if (pause_active) pause_hi_cnt++;
        if (pause_chk && pause_active && ord_ptr >= 1) check("pause_no_grant", busy, 0);
        prev_eof = 1'b0;
        if (m_axis_tvalid && m_axis_tready) begin
            if (ord_ptr >= exp_order.size()) begin
                total++;
                bad++;
                $display("FAIL extra_byte: got 0x%0h, expected no transfer (cycle %0d)", m_axis_tdata, cyc);
            end else begin
                ech      = exp_order[ord_ptr];
                exp_last = (exp_idx == len_g - 1);
                check("data", m_axis_tdata, mk_byte(ech, out_frame_no[ech], exp_idx));
                check("active_ch", active_ch, ech);
                check("tlast", m_axis_tlast, exp_last);
                if (exp_last) begin
                    check("tuser", m_axis_tuser, bad_mask_g[ech]);
                    $display("frame ch=%0d no=%0d len=%0d tuser=%0b cycle=%0d",
                             ech, out_frame_no[ech], len_g, m_axis_tuser, cyc);
                    out_frame_no[ech]++;
                    ord_ptr++;
                    exp_idx  = 0;
                    prev_eof = 1'b1;
                end else begin
                    exp_idx++;
                end
            end
        end
        @(posedge tx_clk);
        #1;
        for (int n = 0; n < CH; n++) begin
            if (hs[n]) begin
                if (byte_idx[n] == len_g - 1) begin
                    byte_idx[n] = 0;
                    frame_no[n]++;
                    frames_left[n]--;
                end else begin
                    byte_idx[n]++;
                end
            end
        end
        if (toggle_g) m_axis_tready = ~m_axis_tready;
        pause_req = (cyc == pulse_at);
        drive_inputs();
        cyc++;
    endtask

    task automatic run_all();
        while (ord_ptr < exp_order.size() && cyc < 3000) cycle();
        check("frames_out", ord_ptr, exp_order.size());
    endtask

    task automatic check_counts(input logic [15:0] g, input logic [15:0] b);
        @(negedge tx_clk);
        check("good_cnt", good_frame_cnt, g);
        check("bad_cnt", bad_frame_cnt, b);
    endtask

    initial begin
        //            mask     nfr len bad      tog norder order             good      bad
        vecs[0] = '{4'b0101, 1,  10, 4'b0000, 1'b0, 2,  48'h20,           16'h0101, 16'h0000};
        vecs[1] = '{4'b1111, 3,  10, 4'b0000, 1'b0, 12, 48'h321032103210, 16'h3333, 16'h0000};
        vecs[2] = '{4'b1000, 1,  6,  4'b1000, 1'b0, 1,  48'h3,            16'h0000, 16'h1000};
        vecs[3] = '{4'b0110, 2,  7,  4'b0000, 1'b1, 4,  48'h2121,         16'h0220, 16'h0000};
        vecs[4] = '{4'b1001, 1,  3,  4'b0001, 1'b0, 2,  48'h30,           16'h1000, 16'h0001};

        for (int v = 0; v < 5; v++) begin
            do_reset();
            exp_order.delete();
            for (int k = 0; k < vecs[v].norder; k++) begin
                exp_order.push_back(int'(vecs[v].order[k*4 +: 4]));
            end
            setup(vecs[v].mask, vecs[v].nframes, vecs[v].len, vecs[v].bad_mask, vecs[v].toggle);
            run_all();
            check_counts(vecs[v].exp_good, vecs[v].exp_bad);
        end

        // 17 good frames on a 4-bit counter wrap to 1.
        do_reset();
        exp_order.delete();
        for (int k = 0; k < 17; k++) exp_order.push_back(0);
        setup(4'b0001, 17, 2, 4'b0000, 1'b0);
        run_all();
        check_counts(16'h0001, 16'h0000);

        // Pause of 2 quanta loaded mid-frame on ch1; ch2 must wait it out.
        do_reset();
        exp_order.delete();
        exp_order.push_back(1);
        exp_order.push_back(2);
        pause_quanta = 16'd2;
        setup(4'b0110, 1, 10, 4'b0000, 1'b0);
        pulse_at  = 3;
        pause_chk = 1'b1;
        run_all();
        check("pause_active_cycles", pause_hi_cnt, 128);
        check_counts(16'h0110, 16'h0000);

        // Reset in the middle of the second frame on ch0.
        do_reset();
        exp_order.delete();
        exp_order.push_back(0);
        exp_order.push_back(0);
        setup(4'b0001, 2, 10, 4'b0000, 1'b0);
        repeat (14) cycle();
        check("pre_reset_busy", busy, 1);
        check("pre_reset_good", good_frame_cnt, 16'h0001);
        tx_rst = 1'b1;
        @(negedge tx_clk);
        check("midrst_m_tvalid", m_axis_tvalid, 0);
        check("midrst_s_tready", s_axis_tready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_active_ch", active_ch, 0);
        check("midrst_good_cnt", good_frame_cnt, 0);
        check("midrst_bad_cnt", bad_frame_cnt, 0);

        // Pause load followed by quanta 0 cancels immediately.
        for (int n = 0; n < CH; n++) frames_left[n] = 0;
        drive_inputs();
        tx_rst = 1'b0;
        @(posedge tx_clk);
        #1;
        pause_req    = 1'b1;
        pause_quanta = 16'd2;
        @(negedge tx_clk);
        check("pause_before_load", pause_active, 0);
        @(posedge tx_clk);
        #1;
        pause_quanta = 16'd0;
        @(negedge tx_clk);
        check("pause_after_load", pause_active, 1);
        @(posedge tx_clk);
        #1;
        pause_req = 1'b0;
        @(negedge tx_clk);
        check("pause_cancel", pause_active, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
